// File: rtl/team_06_audio_pkg.sv
// Shared definitions for the team_06 audio chain (volume shifter, PWM output
// stage and later audio stages).
package team_06_audio_pkg;

    localparam int AUDIO_W = 8;

    // Midscale of an unsigned sample: 50 % duty, which is silence after the RC filter.
    localparam logic [AUDIO_W-1:0] AUDIO_MIDSCALE = 8'd128;

    typedef logic [AUDIO_W-1:0] audio_sample_t;

endpackage

// File: rtl/team_06_sample_fifo.sv
// Small synchronous sample FIFO with first-word-fall-through read data.
// full/empty come from a registered occupancy count, so neither depends
// combinationally on push or pop.
module team_06_sample_fifo
    import team_06_audio_pkg::*;
#(
    parameter int WIDTH = AUDIO_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_push;
    logic w_pop;

    // Push into a full FIFO and pop from an empty one are ignored.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];

    // Sample storage; contents need no reset because the count marks them invalid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/team_06_pwm_audio_out.sv
// PWM audio output stage: buffers volume-scaled samples in a small FIFO and
// plays one sample per PWM period on a single pin. When the FIFO is empty at
// a period wrap the last duty is repeated and a sticky underrun flag is set.
module team_06_pwm_audio_out
    import team_06_audio_pkg::*;
#(
    parameter int WIDTH      = AUDIO_W,
    parameter int PRESCALE   = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic             clear_underrun,
    output logic             pwm_out,
    output logic             period_done,
    output logic             underrun
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] DUTY_RST = {1'b1, {(WIDTH-1){1'b0}}};

    logic [PRE_W-1:0] r_pre_cnt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_duty;
    logic             r_pwm;
    logic             r_period_done;
    logic             r_underrun;

    logic             w_tick;
    logic             w_wrap;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    // Ready is held low during reset even though the cleared FIFO already reports not-full.
    assign sample_ready = ~w_full & ~rst;
    assign w_push       = sample_valid & sample_ready;

    assign w_tick = enable & (r_pre_cnt == PRE_MAX);
    assign w_wrap = w_tick & (r_cnt == {WIDTH{1'b1}});

    // Only a wrap that finds data pops; a push on the same wrap into an empty
    // FIFO is not bypassed and plays one period later.
    assign w_pop = w_wrap & ~w_empty;

    assign pwm_out     = r_pwm;
    assign period_done = r_period_done;
    assign underrun    = r_underrun;

    team_06_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (sample_in),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Prescaler and period counter; both are parked at 0 while disabled so a re-enable starts a fresh period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_cnt <= '0;
            r_cnt     <= '0;
        end else if (!enable) begin
            r_pre_cnt <= '0;
            r_cnt     <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
            r_cnt     <= r_cnt + 1'b1;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

    // Duty register: loaded from the FIFO head at each wrap that finds a sample, otherwise held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty <= DUTY_RST;
        end else if (w_pop) begin
            r_duty <= w_head;
        end
    end

    // Registered compare and wrap pulse; pwm_out lags the counter by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwm         <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_pwm         <= enable & (r_cnt < r_duty);
            r_period_done <= w_wrap;
        end
    end

    // Sticky underrun; a starving wrap in the same cycle overrides a clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun <= 1'b0;
        end else if (w_wrap & w_empty) begin
            r_underrun <= 1'b1;
        end else if (clear_underrun) begin
            r_underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_team_06_pwm_audio_out.sv
// Directed bench for team_06_pwm_audio_out (WIDTH 8, PRESCALE 1, FIFO_DEPTH 2).
module tb_team_06_pwm_audio_out;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       clear_underrun;
    logic       pwm_out;
    logic       period_done;
    logic       underrun;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       push;
        logic [7:0] val;
        logic       clr;
        int         exp_high;
        logic       exp_ur;
    } vec_t;

    vec_t vecs [8];

    team_06_pwm_audio_out #(
        .WIDTH      (8),
        .PRESCALE   (1),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .clear_underrun (clear_underrun),
        .pwm_out        (pwm_out),
        .period_done    (period_done),
        .underrun       (underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for the negedge at which period_done is high.
    task automatic wait_pd(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (period_done) break;
        end
    endtask

    // Called at the negedge where period_done is seen; samples the 256 clocks of the new period.
    // Optionally pushes one sample and/or pulses clear_underrun on the first edge.
    task automatic measure(input logic push, input logic [7:0] val, input logic clr,
                           output int high, output int pd_mid, output int pd_last,
                           output int ready_seen);
        sample_valid   = push;
        sample_in      = val;
        clear_underrun = clr;
        ready_seen     = int'(sample_ready);
        high    = 0;
        pd_mid  = 0;
        pd_last = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            sample_valid   = 1'b0;
            clear_underrun = 1'b0;
            high += int'(pwm_out);
            if (i < 255) pd_mid += int'(period_done);
            else         pd_last = int'(period_done);
        end
    endtask

    // Measure one period and check its high count and exact 256-clock length.
    task automatic play(input string name, input logic push, input logic [7:0] val,
                        input logic clr, input int exp_high);
        int h, pm, pl, rs;
        measure(push, val, clr, h, pm, pl, rs);
        check({name, "_high"}, h, exp_high);
        check({name, "_pd_len"}, pm * 2 + pl, 1);
        if (push) check({name, "_ready_at_push"}, rs, 1);
    endtask

    initial begin
        int n, h, pm, pl, rs, leak, acc_pwm, acc_pd, acc_ur;

        vecs[0] = '{push: 1'b1, val: 8'd64,  clr: 1'b1, exp_high: 128, exp_ur: 1'b0};
        vecs[1] = '{push: 1'b1, val: 8'd192, clr: 1'b0, exp_high: 64,  exp_ur: 1'b0};
        vecs[2] = '{push: 1'b1, val: 8'd0,   clr: 1'b0, exp_high: 192, exp_ur: 1'b0};
        vecs[3] = '{push: 1'b1, val: 8'd255, clr: 1'b0, exp_high: 0,   exp_ur: 1'b0};
        vecs[4] = '{push: 1'b0, val: 8'd0,   clr: 1'b0, exp_high: 255, exp_ur: 1'b1};
        vecs[5] = '{push: 1'b0, val: 8'd0,   clr: 1'b1, exp_high: 255, exp_ur: 1'b1};
        vecs[6] = '{push: 1'b1, val: 8'd1,   clr: 1'b1, exp_high: 255, exp_ur: 1'b0};
        vecs[7] = '{push: 1'b0, val: 8'd0,   clr: 1'b0, exp_high: 1,   exp_ur: 1'b1};

        rst            = 1'b1;
        enable         = 1'b1;
        sample_in      = 8'd0;
        sample_valid   = 1'b0;
        clear_underrun = 1'b0;

        // Reset state and first free-running period at midscale.
        repeat (3) @(negedge clk);
        check("rst_ready", int'(sample_ready), 0);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_pd", int'(period_done), 0);
        check("rst_underrun", int'(underrun), 0);
        rst = 1'b0;
        #1;
        check("release_ready", int'(sample_ready), 1);
        wait_pd(600, n);
        check("first_wrap_clocks", n, 256);
        check("first_wrap_underrun", int'(underrun), 1);
        play("idle_mid", 1'b0, 8'd0, 1'b0, 128);

        // One sample per period, pushed at the start of each period.
        for (int v = 0; v < 8; v++) begin
            play($sformatf("vec%0d", v), vecs[v].push, vecs[v].val, vecs[v].clr, vecs[v].exp_high);
            check($sformatf("vec%0d_underrun", v), int'(underrun), int'(vecs[v].exp_ur));
        end

        // Fill the FIFO and hold a third sample against back-pressure.
        sample_valid = 1'b1;
        sample_in    = 8'd10;
        check("fill_ready0", int'(sample_ready), 1);
        @(negedge clk);
        sample_in = 8'd20;
        @(negedge clk);
        sample_in = 8'd30;
        check("full_ready", int'(sample_ready), 0);
        leak = 0;
        for (n = 0; n < 600; n++) begin
            @(negedge clk);
            if (period_done) break;
            if (sample_ready) leak++;
        end
        check("full_wait_pd", int'(period_done), 1);
        check("full_ready_leak", leak, 0);
        check("ready_after_pop", int'(sample_ready), 1);
        play("q10", 1'b1, 8'd30, 1'b0, 10);
        play("q20", 1'b0, 8'd0, 1'b0, 20);
        play("q30", 1'b0, 8'd0, 1'b0, 30);
        play("drain_repeat", 1'b0, 8'd0, 1'b0, 30);
        check("drain_underrun", int'(underrun), 1);

        // Clear mid-period, then clear on a starving wrap.
        clear_underrun = 1'b1;
        @(negedge clk);
        clear_underrun = 1'b0;
        check("clear_mid", int'(underrun), 0);
        repeat (254) @(negedge clk);
        clear_underrun = 1'b1;
        @(negedge clk);
        clear_underrun = 1'b0;
        check("clear_on_wrap_pd", int'(period_done), 1);
        check("clear_on_wrap_ur", int'(underrun), 1);

        // Disable mid-period at cnt 100, push while disabled, re-enable.
        play("pre_dis", 1'b1, 8'd200, 1'b0, 30);
        repeat (100) @(negedge clk);
        check("dis_pwm_before", int'(pwm_out), 1);
        enable = 1'b0;
        @(negedge clk);
        check("dis_pwm_after", int'(pwm_out), 0);
        check("dis_pd_after", int'(period_done), 0);
        sample_valid   = 1'b1;
        sample_in      = 8'd50;
        clear_underrun = 1'b1;
        check("dis_ready", int'(sample_ready), 1);
        @(negedge clk);
        sample_valid   = 1'b0;
        clear_underrun = 1'b0;
        acc_pwm = 0;
        acc_pd  = 0;
        acc_ur  = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            acc_pwm += int'(pwm_out);
            acc_pd  += int'(period_done);
            acc_ur  += int'(underrun);
        end
        check("dis_pwm_quiet", acc_pwm, 0);
        check("dis_pd_quiet", acc_pd, 0);
        check("dis_ur_quiet", acc_ur, 0);
        enable = 1'b1;
        play("reen_200", 1'b0, 8'd0, 1'b0, 200);
        check("reen_underrun", int'(underrun), 0);
        play("reen_50", 1'b0, 8'd0, 1'b0, 50);
        check("reen50_underrun", int'(underrun), 1);

        // Asynchronous reset at cnt 77 with two samples queued.
        sample_valid = 1'b1;
        sample_in    = 8'd90;
        @(negedge clk);
        sample_in = 8'd91;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (75) @(negedge clk);
        check("prerst_ready_full", int'(sample_ready), 0);
        rst = 1'b1;
        #1;
        check("midrst_pwm", int'(pwm_out), 0);
        check("midrst_pd", int'(period_done), 0);
        check("midrst_underrun", int'(underrun), 0);
        check("midrst_ready", int'(sample_ready), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("postrst_ready", int'(sample_ready), 1);
        wait_pd(600, n);
        check("postrst_wrap_clocks", n, 256);
        check("postrst_underrun", int'(underrun), 1);
        measure(1'b0, 8'd0, 1'b0, h, pm, pl, rs);
        check("postrst_mid_high", h, 128);
        check("postrst_pd_len", pm * 2 + pl, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
